// File: rtl/tlul_host_arbiter.sv
// ---------------------------------------------------------------------------
// tlul_host_arbiter
//   Shares one TL-UL device port between NumHosts TL-UL hosts. A round-robin
//   arbiter picks the A-channel winner each cycle and holds that grant while a
//   presented beat is stalled. Every accepted request pushes its host index
//   into an in-order routing FIFO. The FIFO head steers the D-channel response
//   back to the issuing host. a_source is passed through untouched.
//
//   Optional build macro: TLUL_ARB_HOST0_PRIO_EN
//     When defined, host 0 wins whenever it is valid and no lock is held.
//     Host-0 grants do not advance rr_ptr, so the remaining hosts rotate
//     among themselves. When undefined, all hosts share one round robin.
//
//   Parameters
//     NumHosts       host ports, 2..8
//     MaxOutstanding routing FIFO depth, 1..16
//   Ports
//     clk_i, rst_ni  clock and asynchronous active-low reset
//     tl_h_i / tl_h_o  per-host request in, per-host a_ready + response out
//     tl_d_o / tl_d_i  shared device request out, device a_ready + response in
//     busy_o         high while accepted requests are still unanswered
// ---------------------------------------------------------------------------

package tlul_pkg;

  localparam logic [2:0] TlPutFullData    = 3'd0;
  localparam logic [2:0] TlPutPartialData = 3'd1;
  localparam logic [2:0] TlGet            = 3'd4;
  localparam logic [2:0] TlAccessAck      = 3'd0;
  localparam logic [2:0] TlAccessAckData  = 3'd1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tlul_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tlul_d2h_t;

endpackage

// ---------------------------------------------------------------------------
// tlul_host_arbiter_port
//   Per-host return path. Builds one host's tlul_d2h_t from the grant and
//   routing decisions. A host that does not own the FIFO head sees a fully
//   zeroed response.
//   grant_i  : this host is the valid A-channel winner
//   a_open_i : device ready, FIFO not full, out of reset
//   route_i  : this host owns the routing FIFO head
// ---------------------------------------------------------------------------
module tlul_host_arbiter_port (
  input  logic                tlul_grant_unused_i,
  input  logic                grant_i,
  input  logic                a_open_i,
  input  logic                route_i,
  input  tlul_pkg::tlul_d2h_t tl_d_i,
  output tlul_pkg::tlul_d2h_t tl_h_o
);

  logic unused_in;
  assign unused_in = tlul_grant_unused_i;

  always_comb begin
    tl_h_o = '0;
    if (route_i) tl_h_o = tl_d_i;
    tl_h_o.a_ready = grant_i & a_open_i;
  end

endmodule

module tlul_host_arbiter
  import tlul_pkg::*;
#(
  parameter int unsigned NumHosts       = 4,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  tlul_h2d_t [NumHosts-1:0] tl_h_i,
  output tlul_d2h_t [NumHosts-1:0] tl_h_o,
  output tlul_h2d_t                tl_d_o,
  input  tlul_d2h_t                tl_d_i,
  output logic                     busy_o
);

  localparam int unsigned HostW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
  localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);

  // ---- state --------------------------------------------------------------
  logic [HostW-1:0]                      rr_ptr_q, rr_ptr_d;
  logic                                  lock_q, lock_d;
  logic [HostW-1:0]                      lock_idx_q, lock_idx_d;
  logic [MaxOutstanding-1:0][HostW-1:0]  fifo_q, fifo_d;
  logic [PtrW-1:0]                       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]                       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]                       count_q, count_d;

  // ---- helpers ------------------------------------------------------------
  function automatic int wrap_host(input int v);
    return (v >= int'(NumHosts)) ? v - int'(NumHosts) : v;
  endfunction

  function automatic logic [HostW-1:0] host_inc(input logic [HostW-1:0] h);
    return (h == HostW'(NumHosts - 1)) ? '0 : h + 1'b1;
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---- request vector / FIFO status --------------------------------------
  logic [NumHosts-1:0] req_vec;
  logic [NumHosts-1:0] route_vec;
  logic                full, empty;
  logic [HostW-1:0]    head;

  always_comb begin
    for (int i = 0; i < int'(NumHosts); i++) req_vec[i] = tl_h_i[i].a_valid;
  end

  assign full   = (count_q == CntW'(MaxOutstanding));
  assign empty  = (count_q == '0);
  assign head   = fifo_q[rd_ptr_q];
  assign busy_o = !empty;

  // ---- arbitration --------------------------------------------------------
  // Round-robin scan: first valid host at or after rr_ptr_q, wrapping.
  logic [HostW-1:0] scan_idx;
  logic [HostW-1:0] rr_idx;
  logic             rr_hit;
  logic [HostW-1:0] pick;
  logic [HostW-1:0] winner;
  logic             win_vld;

  always_comb begin
    rr_hit   = 1'b0;
    rr_idx   = rr_ptr_q;
    scan_idx = rr_ptr_q;
    for (int k = 0; k < int'(NumHosts); k++) begin
      scan_idx = HostW'(wrap_host(int'(rr_ptr_q) + k));
      if (!rr_hit && req_vec[scan_idx]) begin
        rr_hit = 1'b1;
        rr_idx = scan_idx;
      end
    end
  end

`ifdef TLUL_ARB_HOST0_PRIO_EN
  assign pick = req_vec[0] ? '0 : rr_idx;
`else
  assign pick = rr_idx;
`endif

  // A held lock overrides everything so a stalled beat stays stable.
  assign winner  = lock_q ? lock_idx_q : pick;
  assign win_vld = req_vec[winner];

  // Outputs are combinational, so reset is folded in here to keep a_valid
  // and a_ready low while rst_ni is held, regardless of host a_valid.
  logic a_open;
  logic a_go;
  logic push, pop, stall;

  assign a_open = tl_d_i.a_ready && !full && rst_ni;
  assign a_go   = win_vld && !full && rst_ni;
  assign push   = a_go && tl_d_i.a_ready;
  assign stall  = a_go && !tl_d_i.a_ready;

  // ---- device request -----------------------------------------------------
  always_comb begin
    tl_d_o = '0;
    if (win_vld && rst_ni) tl_d_o = tl_h_i[winner];
    tl_d_o.a_valid = a_go;
    // With nothing outstanding any response is stray; sink it.
    tl_d_o.d_ready = empty ? 1'b1 : tl_h_i[head].d_ready;
  end

  assign pop = tl_d_i.d_valid && tl_d_o.d_ready && !empty;

  // ---- per-host return path ----------------------------------------------
  for (genvar g = 0; g < int'(NumHosts); g++) begin : g_port
    localparam logic [HostW-1:0] Idx = HostW'(g);
    assign route_vec[g] = !empty && (head == Idx);
    tlul_host_arbiter_port u_port (
      .tlul_grant_unused_i (1'b0),
      .grant_i             (win_vld && (winner == Idx)),
      .a_open_i            (a_open),
      .route_i             (route_vec[g]),
      .tl_d_i              (tl_d_i),
      .tl_h_o              (tl_h_o[g])
    );
  end

  // ---- next state ---------------------------------------------------------
  logic adv_rr;

`ifdef TLUL_ARB_HOST0_PRIO_EN
  assign adv_rr = (winner != '0);
`else
  assign adv_rr = 1'b1;
`endif

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (push) begin
      lock_d = 1'b0;
      if (adv_rr) rr_ptr_d = host_inc(winner);
    end else if (stall) begin
      lock_d     = 1'b1;
      lock_idx_d = winner;
    end
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = winner;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    // push is already blocked by a full FIFO at the start of the cycle, so a
    // simultaneous push and pop leaves the count unchanged.
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      fifo_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_tlul_host_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tlul_host_arbiter
//   Directed bench for tlul_host_arbiter (NumHosts = 4, MaxOutstanding = 4).
//   A queue-based reference model checks every output on every falling edge;
//   literal expectations pin grant orders, held stall data and FIFO-full timing.
// ---------------------------------------------------------------------------
module tb_tlul_host_arbiter;
  import tlul_pkg::*;

  localparam int NH = 4;
  localparam int MO = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  tlul_h2d_t [NH-1:0]  tl_h_i;
  tlul_d2h_t [NH-1:0]  tl_h_o;
  tlul_h2d_t           tl_d_o;
  tlul_d2h_t           tl_d_i;
  logic                busy;

  always #5 clk = ~clk;

  tlul_host_arbiter #(.NumHosts(NH), .MaxOutstanding(MO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .tl_h_i (tl_h_i),
    .tl_h_o (tl_h_o),
    .tl_d_o (tl_d_o),
    .tl_d_i (tl_d_i),
    .busy_o (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
  endtask

  // ---- stimulus controls -------------------------------------------------
  bit [NH-1:0] req_en;
  bit          dev_rdy, resp_en, stray, rst_req;
  int          addr_cnt [NH];

  typedef struct { logic [7:0] src; logic [31:0] addr; } rsp_t;
  rsp_t rsp_q [$];
  int   grant_log [$];

  function automatic logic [31:0] haddr(input int h, input int n);
    return 32'h1000_0000 + 32'(h) * 32'h100 + 32'(n) * 32'd4;
  endfunction

  function automatic void drive();
    rst_n = rst_req;
    for (int i = 0; i < NH; i++) begin
      tl_h_i[i]           = '0;
      tl_h_i[i].a_valid   = req_en[i];
      tl_h_i[i].a_opcode  = TlGet;
      tl_h_i[i].a_size    = 2'd2;
      tl_h_i[i].a_mask    = 4'hf;
      tl_h_i[i].a_source  = 8'(8'h10 + i);
      tl_h_i[i].a_address = haddr(i, addr_cnt[i]);
      tl_h_i[i].a_data    = {16'hDA7A, 8'(i), 8'(addr_cnt[i])};
      tl_h_i[i].d_ready   = 1'b1;
    end
    tl_d_i         = '0;
    tl_d_i.a_ready = dev_rdy;
    if (stray) begin
      tl_d_i.d_valid  = 1'b1;
      tl_d_i.d_opcode = TlAccessAckData;
      tl_d_i.d_source = 8'hEE;
      tl_d_i.d_data   = 32'hDEAD_BEEF;
    end else if (resp_en && rsp_q.size() > 0) begin
      tl_d_i.d_valid  = 1'b1;
      tl_d_i.d_opcode = TlAccessAckData;
      tl_d_i.d_size   = 2'd2;
      tl_d_i.d_source = rsp_q[0].src;
      tl_d_i.d_data   = rsp_q[0].addr ^ 32'h5A5A_0000;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // ---- reference model ---------------------------------------------------
  int        m_q [$];
  int        m_rr = 0;
  bit        m_lock = 0;
  int        m_lock_idx = 0;
  int        m_w, m_head;
  bit        m_wv, m_full, m_route;
  tlul_h2d_t m_a;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_a_valid", tl_d_o.a_valid, 0);
      chk("rst_d_ready", tl_d_o.d_ready, 1);
      chk("rst_busy", busy, 0);
      for (int i = 0; i < NH; i++) begin
        chk("rst_a_ready", tl_h_o[i].a_ready, 0);
        chk("rst_d_valid", tl_h_o[i].d_valid, 0);
      end
      m_q.delete();
      m_rr = 0; m_lock = 0; m_lock_idx = 0;
    end else begin
      m_full = (m_q.size() == MO);
      if (m_lock) m_w = m_lock_idx;
      else begin
        m_w = -1;
`ifdef TLUL_ARB_HOST0_PRIO_EN
        if (tl_h_i[0].a_valid) m_w = 0;
`endif
        for (int k = 0; k < NH; k++)
          if (m_w < 0 && tl_h_i[(m_rr + k) % NH].a_valid) m_w = (m_rr + k) % NH;
      end
      m_wv = 1'b0;
      if (m_w >= 0) m_wv = tl_h_i[m_w].a_valid;
      m_head = (m_q.size() > 0) ? m_q[0] : -1;
      m_a = '0;
      if (m_wv) m_a = tl_h_i[m_w];

      chk("a_valid", tl_d_o.a_valid, m_wv && !m_full);
      chk("a_address", tl_d_o.a_address, m_a.a_address);
      chk("a_data", tl_d_o.a_data, m_a.a_data);
      chk("a_source", tl_d_o.a_source, m_a.a_source);
      if (m_head < 0) chk("d_ready", tl_d_o.d_ready, 1);
      else            chk("d_ready", tl_d_o.d_ready, tl_h_i[m_head].d_ready);
      chk("busy", busy, m_q.size() != 0);
      for (int i = 0; i < NH; i++) begin
        m_route = (i == m_head);
        chk("a_ready", tl_h_o[i].a_ready, (i == m_w) && m_wv && tl_d_i.a_ready && !m_full);
        chk("d_valid", tl_h_o[i].d_valid, m_route && tl_d_i.d_valid);
        chk("d_data", tl_h_o[i].d_data, m_route ? tl_d_i.d_data : 32'h0);
        chk("d_source", tl_h_o[i].d_source, m_route ? tl_d_i.d_source : 8'h0);
        if (tl_h_o[i].d_valid) chk("d_src_owner", tl_h_o[i].d_source, 8'(8'h10 + i));
      end

      if (tl_d_i.d_valid && m_head >= 0 && tl_h_i[m_head].d_ready) m_q.pop_front();
      if (m_wv && !m_full) begin
        if (tl_d_i.a_ready) begin
          m_q.push_back(m_w);
          m_lock = 0;
`ifdef TLUL_ARB_HOST0_PRIO_EN
          if (m_w != 0) m_rr = (m_w + 1) % NH;
`else
          m_rr = (m_w + 1) % NH;
`endif
        end else begin
          m_lock = 1;
          m_lock_idx = m_w;
        end
      end
    end

    // Host and device behaviour reacts to what the DUT presented this cycle.
    if (tl_d_i.d_valid && tl_d_o.d_ready && !stray && rsp_q.size() > 0) rsp_q.pop_front();
    for (int i = 0; i < NH; i++)
      if (tl_h_i[i].a_valid && tl_h_o[i].a_ready) begin
        grant_log.push_back(i);
        addr_cnt[i]++;
      end
    if (tl_d_o.a_valid && tl_d_i.a_ready)
      rsp_q.push_back('{tl_d_o.a_source, tl_d_o.a_address});
  end

  // ---- directed sequence -------------------------------------------------
  int gl0;

  initial begin
    for (int i = 0; i < NH; i++) addr_cnt[i] = 0;
    rst_req = 1'b0; req_en = '1; dev_rdy = 1'b1; resp_en = 1'b1; stray = 1'b0;
    drive();

    // Reset held with every host requesting.
    repeat (3) step();
    settle();
    chk("reset_a_valid", tl_d_o.a_valid, 0);
    chk("reset_a_ready", {tl_h_o[3].a_ready, tl_h_o[2].a_ready, tl_h_o[1].a_ready, tl_h_o[0].a_ready}, 0);
    chk("reset_busy", busy, 0);
    chk("reset_d_ready", tl_d_o.d_ready, 1);

    // Release: round robin across four continuously requesting hosts.
    rst_req = 1'b1;
    repeat (6) step();
    req_en = '0;
    repeat (4) step();
    chk("rr_count", grant_log.size(), 6);
    chk("rr_g0", grant_log[0], 0);
    chk("rr_g1", grant_log[1], 1);
    chk("rr_g2", grant_log[2], 2);
    chk("rr_g3", grant_log[3], 3);
    chk("rr_g4", grant_log[4], 0);
    settle();
    chk("rr_drained", busy, 0);

    // Stall lock: host 2 is next in rotation, device stalls for 3 cycles.
    dev_rdy = 1'b0; req_en = 4'b0100;
    step(); settle();
    chk("stall_addr0", tl_d_o.a_address, 32'h1000_0204);
    chk("stall_data0", tl_d_o.a_data, 32'hDA7A_0201);
    req_en = 4'b0101;
    step(); settle();
    chk("stall_addr1", tl_d_o.a_address, 32'h1000_0204);
    chk("stall_h0_rdy", tl_h_o[0].a_ready, 0);
    step(); settle();
    chk("stall_addr2", tl_d_o.a_address, 32'h1000_0204);
    chk("stall_data2", tl_d_o.a_data, 32'hDA7A_0201);
    gl0 = grant_log.size();
    dev_rdy = 1'b1;
    step(); step();
    req_en = '0;
    repeat (4) step();
    chk("stall_first", grant_log[gl0], 2);
    chk("stall_next", grant_log[gl0 + 1], 0);

    // Full FIFO: four Gets outstanding, host 1 keeps requesting.
    resp_en = 1'b0; req_en = '1;
    repeat (4) step();
    req_en = 4'b0010;
    step(); settle();
    chk("full_a_valid", tl_d_o.a_valid, 0);
    chk("full_h1_rdy", tl_h_o[1].a_ready, 0);
    chk("full_busy", busy, 1);
    resp_en = 1'b1;
    step(); settle();
    chk("pop_cyc_a_valid", tl_d_o.a_valid, 0);
    chk("pop_cyc_h1_dvld", tl_h_o[1].d_valid, 1);
    step(); settle();
    chk("after_pop_h1_rdy", tl_h_o[1].a_ready, 1);
    chk("after_pop_a_valid", tl_d_o.a_valid, 1);
    req_en = '0;
    repeat (6) step();

    // Stray response with nothing outstanding.
    stray = 1'b1;
    step(); settle();
    chk("stray_d_ready", tl_d_o.d_ready, 1);
    chk("stray_d_valid", {tl_h_o[3].d_valid, tl_h_o[2].d_valid, tl_h_o[1].d_valid, tl_h_o[0].d_valid}, 0);
    stray = 1'b0;
    step();

    // Reset mid-operation with two requests outstanding.
    resp_en = 1'b0; req_en = '1;
    repeat (2) step();
    rst_req = 1'b0;
    step(); settle();
    chk("midrst_a_valid", tl_d_o.a_valid, 0);
    chk("midrst_busy", busy, 0);
    req_en = '0; rst_req = 1'b1; resp_en = 1'b1;
    step(); settle();
    chk("late_rsp_dvld", {tl_h_o[3].d_valid, tl_h_o[2].d_valid, tl_h_o[1].d_valid, tl_h_o[0].d_valid}, 0);
    chk("late_rsp_drdy", tl_d_o.d_ready, 1);
    repeat (3) step();

    // Hosts 0 and 1 requesting continuously.
    gl0 = grant_log.size();
    req_en = 4'b0011;
    repeat (4) step();
    req_en = '0;
    repeat (4) step();
`ifdef TLUL_ARB_HOST0_PRIO_EN
    chk("pair_g0", grant_log[gl0], 0);
    chk("pair_g1", grant_log[gl0 + 1], 0);
    chk("pair_g2", grant_log[gl0 + 2], 0);
    chk("pair_g3", grant_log[gl0 + 3], 0);
`else
    chk("pair_g0", grant_log[gl0], 0);
    chk("pair_g1", grant_log[gl0 + 1], 1);
    chk("pair_g2", grant_log[gl0 + 2], 0);
    chk("pair_g3", grant_log[gl0 + 3], 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
